input_vc_buffer: RTL and testbench

//  Per-input-port flit steering and buffering stage, directly downstream of the route computation.

---
 rtl/input_vc_buffer.sv | 88 ++++++++
 tb/tb_input_vc_buffer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/input_vc_buffer.sv
// input_vc_buffer: steers flits into per-direction VC FIFOs, locking each packet's route at its head
module input_vc_buffer #(
  parameter int MSB_SLOT = 5,
  parameter int DSIZE = 1 << MSB_SLOT,
  parameter int NUM_VC = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DSIZE-1:0]        data_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [2:0]              vc_select,
  output logic [NUM_VC*DSIZE-1:0] data_out,
  output logic [NUM_VC-1:0]       vc_valid,
  input  logic [NUM_VC-1:0]       vc_pop,
  output logic                    err_flag,
  output logic [7:0]              drop_cnt
);
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;
  localparam logic [2:0] NVC = 3'(NUM_VC);
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(FIFO_DEPTH);
  state_t state;
  logic [2:0] locked_vc, target;
  logic [DSIZE-1:0] mem [NUM_VC][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr [NUM_VC];
  logic [PTR_W-1:0] wr_ptr [NUM_VC];
  logic [PTR_W:0] count [NUM_VC];
  logic [1:0] ftype;
  logic is_head, is_tail, is_null, head_ok, full_t, accept, live, do_push, do_drop, bad;
  logic [NUM_VC-1:0] push, pop;
  always_comb begin
    ftype = data_in[1:0];
    is_head = ftype == 2'b11;
    is_tail = ftype == 2'b10;
    is_null = ftype == 2'b00;
    head_ok = vc_select < NVC;
    target = (state == IDLE || is_head) ? vc_select : locked_vc;
    full_t = 1'b0;
    for (int i = 0; i < NUM_VC; i++)
      if (target == 3'(i)) full_t = count[i] == FULL;
    ready_out = is_null || target >= NVC || (state == DROP && !is_head) || !full_t;
    accept = valid_in && ready_out;
    live = accept && !is_null;
    do_push = live && (is_head ? head_ok : state == PKT);
    do_drop = live && !do_push;
    bad = live && (is_head ? state != IDLE : state == IDLE);
    for (int i = 0; i < NUM_VC; i++) begin
      push[i] = do_push && target == 3'(i);
      pop[i] = vc_pop[i] && count[i] != '0;
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_VC; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= data_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      locked_vc <= '0;
      err_flag <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < NUM_VC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i] <= '0;
      end
    end else begin
      if (live && is_head) begin
        state <= head_ok ? PKT : DROP;
        if (head_ok) locked_vc <= vc_select;
      end else if (live && is_tail) begin
        state <= IDLE;
      end
      if (bad) err_flag <= 1'b1;
      if (do_drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      for (int i = 0; i < NUM_VC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + {{PTR_W{1'b0}}, push[i]} - {{PTR_W{1'b0}}, pop[i]};
      end
    end
  end
  for (genvar g = 0; g < NUM_VC; g++) begin : g_out
    assign vc_valid[g] = count[g] != '0;
    assign data_out[g*DSIZE +: DSIZE] = vc_valid[g] ? mem[g][rd_ptr[g]] : '0;
  end
endmodule

// File: tb/tb_input_vc_buffer.sv
// tb_input_vc_buffer: directed checks of flit steering, route locking, drops and FIFO flow control
module tb_input_vc_buffer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] data_in = '0;
  logic valid_in = 1'b0;
  logic ready_out;
  logic [2:0] vc_select = 3'd7;
  logic [159:0] data_out;
  logic [4:0] vc_valid;
  logic [4:0] vc_pop = '0;
  logic err_flag;
  logic [7:0] drop_cnt;
  int passed = 0;
  int total = 0;
  input_vc_buffer dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
    .vc_select(vc_select), .data_out(data_out), .vc_valid(vc_valid), .vc_pop(vc_pop),
    .err_flag(err_flag), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [29:0] p, input logic [1:0] t, input logic [2:0] vs);
    data_in = {p, t};
    vc_select = vs;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
  endtask
  function automatic logic [31:0] dout(input int i);
    return data_out[i*32 +: 32];
  endfunction
  localparam logic [1:0] H = 2'b11, B = 2'b01, T = 2'b10, N = 2'b00;
  initial begin
    step();
    step();
    reset = 1'b0;
    check("rst_vc_valid", 32'(vc_valid), 32'h0);
    check("rst_err", 32'(err_flag), 32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    check("rst_dout2", dout(2), 32'h0);
    check("rst_state", 32'(dut.state), 32'h0);
    check("rst_ready", 32'(ready_out), 32'h1);
    send(30'h11, H, 3'd2);
    check("t1_valid_after_head", 32'(vc_valid), 32'h04);
    check("t1_dout_head", dout(2), {30'h11, H});
    check("t1_state_pkt", 32'(dut.state), 32'h1);
    send(30'h12, B, 3'd7);
    send(30'h13, T, 3'd7);
    check("t1_count2", 32'(dut.count[2]), 32'h3);
    check("t1_state_idle", 32'(dut.state), 32'h0);
    check("t1_vc_valid", 32'(vc_valid), 32'h04);
    vc_pop = 5'b00100;
    for (int k = 0; k < 3; k++) begin
      check("t1_drain", dout(2), {30'(32'h11 + k), (k == 0) ? H : (k == 1) ? B : T});
      step();
    end
    vc_pop = '0;
    check("t1_empty", 32'(vc_valid), 32'h0);
    send(30'h21, H, 3'd1);
    for (int k = 0; k < 3; k++) send(30'(32'h22 + k), B, 3'd7);
    check("t2_full_count", 32'(dut.count[1]), 32'h4);
    data_in = {30'h25, T};
    valid_in = 1'b1;
    vc_pop = 5'b00010;
    #1;
    check("t2_ready_full_pop", 32'(ready_out), 32'h0);
    step();
    check("t2_count_after_pop", 32'(dut.count[1]), 32'h3);
    check("t2_head_after_pop", dout(1), {30'h22, B});
    vc_pop = '0;
    #1;
    check("t2_ready_retry", 32'(ready_out), 32'h1);
    step();
    valid_in = 1'b0;
    check("t2_count_refill", 32'(dut.count[1]), 32'h4);
    check("t2_state_idle", 32'(dut.state), 32'h0);
    vc_pop = 5'b00010;
    for (int k = 0; k < 4; k++) begin
      check("t2_drain", dout(1), {30'(32'h22 + k), (k == 3) ? T : B});
      step();
    end
    vc_pop = '0;
    check("t2_err", 32'(err_flag), 32'h0);
    send(30'h31, H, 3'd7);
    check("t3_state_drop", 32'(dut.state), 32'h2);
    send(30'h32, B, 3'd3);
    send(30'h33, B, 3'd3);
    send(30'h34, T, 3'd3);
    check("t3_drop_cnt", 32'(drop_cnt), 32'h4);
    check("t3_state_idle", 32'(dut.state), 32'h0);
    check("t3_err", 32'(err_flag), 32'h0);
    check("t3_vc_valid", 32'(vc_valid), 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    send(30'h41, B, 3'd7);
    check("t4_drop_cnt", 32'(drop_cnt), 32'h1);
    check("t4_err", 32'(err_flag), 32'h1);
    check("t4_vc_valid", 32'(vc_valid), 32'h0);
    send(30'h51, H, 3'd4);
    send(30'h52, B, 3'd7);
    send(30'h53, H, 3'd0);
    check("t5_count4", 32'(dut.count[4]), 32'h2);
    check("t5_count0", 32'(dut.count[0]), 32'h1);
    check("t5_dout0", dout(0), {30'h53, H});
    check("t5_vc_valid", 32'(vc_valid), 32'h11);
    check("t5_err", 32'(err_flag), 32'h1);
    check("t5_locked", 32'(dut.locked_vc), 32'h0);
    check("t5_drop_cnt", 32'(drop_cnt), 32'h1);
    check("t5_state_pkt", 32'(dut.state), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_vc_valid", 32'(vc_valid), 32'h0);
    check("t6_state", 32'(dut.state), 32'h0);
    check("t6_drop_cnt", 32'(drop_cnt), 32'h0);
    check("t6_err", 32'(err_flag), 32'h0);
    check("t6_dout4", dout(4), 32'h0);
    send(30'h61, B, 3'd0);
    check("t6_orphan_drop", 32'(drop_cnt), 32'h1);
    check("t6_orphan_err", 32'(err_flag), 32'h1);
    check("t6_orphan_nowrite", 32'(vc_valid), 32'h0);
    for (int k = 0; k < 260; k++) send(30'h70, B, 3'd7);
    check("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
    vc_pop = '1;
    step();
    vc_pop = '0;
    check("pop_empty_valid", 32'(vc_valid), 32'h0);
    send(30'h81, H, 3'd3);
    check("pop_empty_count3", 32'(dut.count[3]), 32'h1);
    check("pop_empty_dout3", dout(3), {30'h81, H});
    send(30'h82, N, 3'd1);
    check("null_state", 32'(dut.state), 32'h1);
    check("null_count3", 32'(dut.count[3]), 32'h1);
    check("null_count1", 32'(dut.count[1]), 32'h0);
    check("null_drop", 32'(drop_cnt), 32'hFF);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
